// File: rtl/vmx_pkg.sv
// Shared VMX definitions: default bus widths and the
// memory-access FSM state encoding.
package vmx_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WR_WAIT = 2'b01,
    RD_WAIT = 2'b10
  } state_t;

endpackage

// File: rtl/vmx_rw_grant.sv
// Combinational write/read grant decision.
// Ports: i_wr_ok, i_rd_ok, i_sat (streak at limit) -> o_gnt_wr, o_gnt_rd.
module vmx_rw_grant (
  input  logic i_wr_ok,
  input  logic i_rd_ok,
  input  logic i_sat,
  output logic o_gnt_wr,
  output logic o_gnt_rd
);

  // Arms are mutually exclusive: a write wins unless a read
  // is waiting and the write streak has hit its limit.
  always_comb begin
    o_gnt_wr = 1'b0;
    o_gnt_rd = 1'b0;
    unique case (1'b1)
      (i_wr_ok & ~(i_rd_ok & i_sat)): o_gnt_wr = 1'b1;
      (i_rd_ok & ~(i_wr_ok & ~i_sat)): o_gnt_rd = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/vmx_mem_access_arbiter.sv
// Drains VMX read/write queues onto one single-beat memory port.
// Ports: rd/wr/res queue heads+pops, opd queue push, mem req/ack, busy.
module vmx_mem_access_arbiter
  import vmx_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int WR_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_fifo_instr,
  input  logic              rd_fifo_empty,
  output logic              rd_fifo_rena,
  input  logic [ADDR_W-1:0] wr_fifo_instr,
  input  logic              wr_fifo_empty,
  output logic              wr_fifo_rena,
  input  logic [DATA_W-1:0] res_fifo_data,
  input  logic              res_fifo_empty,
  output logic              res_fifo_rena,
  output logic [DATA_W-1:0] opd_fifo_data,
  input  logic              opd_fifo_full,
  output logic              opd_fifo_wren,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int SW = $clog2(WR_STREAK_MAX + 1);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

  state_t              r_state;
  logic [SW-1:0]       r_streak;
  logic                r_req;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_opd;
  logic                r_wren;

  logic                w_idle;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic                w_sat;
  logic                w_gnt_wr;
  logic                w_gnt_rd;
  logic                w_pop_wr;
  logic                w_pop_rd;
  logic [SW-1:0]       w_streak_inc;

  // Pops are held off while reset is asserted.
  assign w_idle  = (r_state == IDLE) & rst_n;
  assign w_wr_ok = ~wr_fifo_empty & ~res_fifo_empty;
  // Space for the returned word is reserved here; we are the
  // only writer of the operand queue.
  assign w_rd_ok = ~rd_fifo_empty & ~opd_fifo_full;
  assign w_sat   = (r_streak >= SW'(WR_STREAK_MAX));
  assign w_streak_inc = w_sat ? r_streak : r_streak + 1'b1;

  vmx_rw_grant u_grant (
    .i_wr_ok  (w_wr_ok),
    .i_rd_ok  (w_rd_ok),
    .i_sat    (w_sat),
    .o_gnt_wr (w_gnt_wr),
    .o_gnt_rd (w_gnt_rd)
  );

  assign w_pop_wr = w_idle & w_gnt_wr;
  assign w_pop_rd = w_idle & w_gnt_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_streak <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_opd    <= '0;
      r_wren   <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pop_wr) begin
            r_state  <= WR_WAIT;
            r_req    <= 1'b1;
            r_we     <= 1'b1;
            r_addr   <= wr_fifo_instr & ALIGN;
            r_wdata  <= res_fifo_data;
            r_streak <= w_rd_ok ? w_streak_inc : '0;
          end else if (w_pop_rd) begin
            r_state  <= RD_WAIT;
            r_req    <= 1'b1;
            r_we     <= 1'b0;
            r_addr   <= rd_fifo_instr & ALIGN;
            r_streak <= '0;
          end
        end
        WR_WAIT: begin
          if (mem_ack) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (mem_ack) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
            r_opd   <= mem_rdata;
            r_wren  <= 1'b1;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rd_fifo_rena  = w_pop_rd;
  assign wr_fifo_rena  = w_pop_wr;
  assign res_fifo_rena = w_pop_wr;
  assign opd_fifo_data = r_opd;
  assign opd_fifo_wren = r_wren;
  assign mem_req       = r_req;
  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_vmx_mem_access_arbiter.sv
// Bench for vmx_mem_access_arbiter: queue/memory environment,
// transaction-level reference model and directed scenarios.
module tb_vmx_mem_access_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rd_fifo_instr = '0;
  logic        rd_fifo_empty = 1'b1;
  logic        rd_fifo_rena;
  logic [31:0] wr_fifo_instr = '0;
  logic        wr_fifo_empty = 1'b1;
  logic        wr_fifo_rena;
  logic [31:0] res_fifo_data = '0;
  logic        res_fifo_empty = 1'b1;
  logic        res_fifo_rena;
  logic [31:0] opd_fifo_data;
  logic        opd_fifo_full = 1'b0;
  logic        opd_fifo_wren;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  always #5 clk = ~clk;

  vmx_mem_access_arbiter #(
    .ADDR_W(32), .DATA_W(32), .WR_STREAK_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_fifo_instr(rd_fifo_instr), .rd_fifo_empty(rd_fifo_empty),
    .rd_fifo_rena(rd_fifo_rena),
    .wr_fifo_instr(wr_fifo_instr), .wr_fifo_empty(wr_fifo_empty),
    .wr_fifo_rena(wr_fifo_rena),
    .res_fifo_data(res_fifo_data), .res_fifo_empty(res_fifo_empty),
    .res_fifo_rena(res_fifo_rena),
    .opd_fifo_data(opd_fifo_data), .opd_fifo_full(opd_fifo_full),
    .opd_fifo_wren(opd_fifo_wren),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic [31:0] rdq[$];
  logic [31:0] wrq[$];
  logic [31:0] resq[$];
  txn_t        dut_log[$];
  logic [31:0] opd_log[$];
  string       order = "";

  int n_run = 0;
  int n_fail = 0;

  int ack_lat = 0;
  int wait_cnt = 0;
  bit spur_pend = 1'b0;
  bit s_rd, s_wr;

  bit          m_busy = 1'b0;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  int          m_streak = 0;
  bit          m_push = 1'b0;
  logic [31:0] m_pdata;

  function automatic logic [31:0] rdata_fn(input logic [31:0] a);
    return (a == 32'h1000_0004) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0F0F);
  endfunction

  function automatic txn_t log_at(input int i);
    txn_t t;
    t = '0;
    if (i < dut_log.size()) t = dut_log[i];
    return t;
  endfunction

  function automatic logic [31:0] opd_at(input int i);
    logic [31:0] v;
    v = '0;
    if (i < opd_log.size()) v = opd_log[i];
    return v;
  endfunction

  function automatic string tail(input int m);
    if (order.len() <= m) return "";
    return order.substr(m, order.len() - 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_str(input string nm, input string act,
                         input string exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got '%s' want '%s'", nm, act, exp);
    end
  endtask

  task automatic refresh();
    rd_fifo_empty  = (rdq.size() == 0);
    rd_fifo_instr  = rd_fifo_empty ? '0 : rdq[0];
    wr_fifo_empty  = (wrq.size() == 0);
    wr_fifo_instr  = wr_fifo_empty ? '0 : wrq[0];
    res_fifo_empty = (resq.size() == 0);
    res_fifo_data  = res_fifo_empty ? '0 : resq[0];
  endtask

  // Reference model + per-cycle comparison, run at the falling edge.
  task automatic compare_model();
    bit wr_ok, rd_ok, e_wr, e_rd;
    if (!rst_n) begin
      chk("rst_req", mem_req, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_opd", opd_fifo_data, 0);
      chk("rst_wren", opd_fifo_wren, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pops", {rd_fifo_rena, wr_fifo_rena, res_fifo_rena}, 0);
      m_busy = 0; m_streak = 0; m_push = 0;
      s_rd = 0; s_wr = 0;
      return;
    end
    wr_ok = (wrq.size() > 0) && (resq.size() > 0);
    rd_ok = (rdq.size() > 0) && !opd_fifo_full;
    e_wr = 0;
    e_rd = 0;
    if (!m_busy) begin
      if (wr_ok && rd_ok) begin
        if (m_streak < SMAX) e_wr = 1;
        else e_rd = 1;
      end else begin
        e_wr = wr_ok;
        e_rd = rd_ok;
      end
    end
    chk("wr_rena", wr_fifo_rena, e_wr);
    chk("res_rena", res_fifo_rena, e_wr);
    chk("rd_rena", rd_fifo_rena, e_rd);
    chk("mem_req", mem_req, m_busy);
    chk("busy", busy, m_busy);
    chk("opd_wren", opd_fifo_wren, m_push);
    if (m_push) chk("opd_data", opd_fifo_data, m_pdata);
    if (m_busy) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (mem_req && mem_ack) dut_log.push_back({mem_we, mem_addr, mem_wdata});
    if (opd_fifo_wren) opd_log.push_back(opd_fifo_data);
    if (wr_fifo_rena) order = {order, "W"};
    if (rd_fifo_rena) order = {order, "R"};
    s_rd = rd_fifo_rena;
    s_wr = wr_fifo_rena;
    m_push = m_busy && mem_ack && !m_we;
    m_pdata = rdata_fn(m_addr);
    if (m_busy) begin
      if (mem_ack) m_busy = 0;
    end else if (e_wr) begin
      m_busy = 1;
      m_we = 1;
      m_addr = {wrq[0][31:2], 2'b00};
      m_wdata = resq[0];
      m_streak = rd_ok ? m_streak + 1 : 0;
    end else if (e_rd) begin
      m_busy = 1;
      m_we = 0;
      m_addr = {rdq[0][31:2], 2'b00};
      m_streak = 0;
    end
  endtask

  // Queue pops and memory responder, just after the rising edge.
  task automatic env();
    if (s_rd && rdq.size() > 0) rdq.delete(0);
    if (s_wr && wrq.size() > 0) wrq.delete(0);
    if (s_wr && resq.size() > 0) resq.delete(0);
    s_rd = 0;
    s_wr = 0;
    mem_ack = 0;
    mem_rdata = 32'h0BAD_F00D;
    if (!rst_n) begin
      wait_cnt = 0;
    end else if (spur_pend) begin
      mem_ack = 1;
      spur_pend = 0;
    end else if (mem_req) begin
      if (wait_cnt >= ack_lat) begin
        mem_ack = 1;
        mem_rdata = rdata_fn(mem_addr);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    refresh();
  endtask

  task automatic step();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #1;
    env();
  endtask

  task automatic drain(input int max);
    int k;
    bit done;
    k = 0;
    done = 0;
    while (!done && k < max) begin
      step();
      k++;
      if (!busy && !mem_req && rdq.size() == 0 &&
          (wrq.size() == 0 || resq.size() == 0)) done = 1;
    end
    repeat (2) step();
    chk("drain_timeout", {31'b0, !done}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mo, lo, oo;
    bit seen;
    repeat (3) step();
    #1 rst_n = 1'b1;
    step();

    // Single read with 3-cycle memory latency.
    ack_lat = 3;
    mo = order.len(); lo = dut_log.size(); oo = opd_log.size();
    rdq.push_back(32'h1000_0004);
    refresh();
    drain(50);
    chk_str("t1_order", tail(mo), "R");
    chk("t1_we", log_at(lo).we, 0);
    chk("t1_addr", log_at(lo).addr, 32'h1000_0004);
    chk("t1_npush", opd_log.size() - oo, 1);
    chk("t1_rdata", opd_at(oo), 32'hDEAD_BEEF);

    // Write and read eligible together: write first.
    ack_lat = 0;
    mo = order.len(); lo = dut_log.size();
    wrq.push_back(32'h2000_0000);
    resq.push_back(32'h1234_5678);
    rdq.push_back(32'h1000_0100);
    refresh();
    drain(50);
    chk_str("t2_order", tail(mo), "WR");
    chk("t2_we", log_at(lo).we, 1);
    chk("t2_addr", log_at(lo).addr, 32'h2000_0000);
    chk("t2_wdata", log_at(lo).wdata, 32'h1234_5678);
    chk("t2_rd_we", log_at(lo + 1).we, 0);

    // Starvation limit.
    mo = order.len();
    for (int i = 0; i < 8; i++) begin
      wrq.push_back(32'h4000_0000 + 32'(4 * i));
      resq.push_back(32'hC0DE_0000 + 32'(i));
    end
    rdq.push_back(32'h5000_0000);
    refresh();
    drain(100);
    chk_str("t3_order", tail(mo), "WWWWRWWWW");

    // Operand queue back-pressure.
    opd_fifo_full = 1'b1;
    mo = order.len();
    rdq.push_back(32'h6000_0000);
    rdq.push_back(32'h6000_0004);
    refresh();
    repeat (5) step();
    chk_str("t4_blocked", tail(mo), "");
    chk("t4_noreq", mem_req, 0);
    opd_fifo_full = 1'b0;
    step();
    chk_str("t4_release", tail(mo), "R");
    drain(50);
    chk_str("t4_order", tail(mo), "RR");

    // Write without result data waits; read proceeds.
    mo = order.len(); lo = dut_log.size();
    wrq.push_back(32'h7000_0000);
    rdq.push_back(32'h7100_0000);
    refresh();
    drain(50);
    chk_str("t5_rd_only", tail(mo), "R");
    resq.push_back(32'hFEED_0001);
    refresh();
    drain(50);
    chk_str("t5_order", tail(mo), "RW");
    chk("t5_waddr", log_at(lo + 1).addr, 32'h7000_0000);
    chk("t5_wdata", log_at(lo + 1).wdata, 32'hFEED_0001);

    // Reset in RD_WAIT, misaligned address, spurious ack.
    ack_lat = 20;
    rdq.push_back(32'h3000_0007);
    refresh();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = mem_req;
    end
    chk("t6_req_seen", seen, 1);
    chk("t6_align", mem_addr, 32'h3000_0004);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_req_drop", mem_req, 0);
    chk("t6_busy_drop", busy, 0);
    repeat (2) step();
    #1 rst_n = 1'b1;
    ack_lat = 0;
    oo = opd_log.size();
    spur_pend = 1'b1;
    repeat (4) step();
    chk("t6_spur_push", opd_log.size() - oo, 0);
    chk("t6_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/vmx_mem_access_arbiter.md
Name: vmx_mem_access_arbiter

Overview:
Memory access processor that drains the read and write data queues filled by the VMX control processor and shares one single-beat memory request port between them.
- Write commands are granted first.
- A starvation limit guarantees that pending reads are eventually served.
- Read data is pushed into the PE operand queue.
- Write data is taken from the PE result queue.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory data width
WR_STREAK_MAX, 4, consecutive write grants allowed while a read is pending before one read is forced

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
rd_fifo_instr  input  ADDR_W  read address at head of read data queue (first-word-fall-through, valid while ~rd_fifo_empty)
rd_fifo_empty  input  1  read data queue empty
rd_fifo_rena  output  1  pop read data queue
wr_fifo_instr  input  ADDR_W  write address at head of write data queue (FWFT)
wr_fifo_empty  input  1  write data queue empty
wr_fifo_rena  output  1  pop write data queue
res_fifo_data  input  DATA_W  PE result word at head of result queue (FWFT)
res_fifo_empty  input  1  result queue empty
res_fifo_rena  output  1  pop result queue
opd_fifo_data  output  DATA_W  operand word to PE operand queue
opd_fifo_full  input  1  operand queue full
opd_fifo_wren  output  1  push operand queue
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  word address; bits [1:0] forced to 0
mem_wdata  output  DATA_W  write data
mem_ack  input  1  one-cycle completion strobe; mem_rdata valid with it for reads
mem_rdata  input  DATA_W  read data
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, streak=0. All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, opd_fifo_data, opd_fifo_wren, busy. The pop signals are also 0.
- Eligibility:
  - wr_ok = ~wr_fifo_empty & ~res_fifo_empty
  - rd_ok = ~rd_fifo_empty & ~opd_fifo_full. Checking opd_fifo_full at grant time guarantees space for the returned word, since the arbiter is the only writer.
- Grant in IDLE (combinational, same cycle):
  - wr_ok & rd_ok & streak<WR_STREAK_MAX -> write.
  - wr_ok & rd_ok & streak==WR_STREAK_MAX -> read.
  - Only one eligible -> that one. Neither -> stay IDLE.
- Write grant:
  - Assert wr_fifo_rena and res_fifo_rena in that cycle.
  - Next edge: mem_addr <= {wr_fifo_instr[ADDR_W-1:2],2'b00}, mem_wdata <= res_fifo_data, mem_we <= 1, mem_req <= 1, state <= WR_WAIT.
  - streak <= streak+1 if rd_ok, else 0.
- Read grant:
  - Assert rd_fifo_rena.
  - Next edge: mem_addr <= aligned rd_fifo_instr, mem_we <= 0, mem_req <= 1, state <= RD_WAIT, streak <= 0.
- Pop signals are combinational from state==IDLE and the grant, so each is high for exactly one cycle per grant.
- WR_WAIT / RD_WAIT:
  - mem_req, mem_addr, mem_we, mem_wdata are held stable until mem_ack.
  - On mem_ack: mem_req <= 0, state <= IDLE.
  - In RD_WAIT, mem_ack also registers opd_fifo_data <= mem_rdata and asserts opd_fifo_wren (registered) for exactly one cycle.
- Latency:
  - Grant to mem_req high: 1 cycle.
  - mem_ack to opd_fifo_wren: 1 cycle.
  - Minimum request-to-request spacing: 2 cycles (mem_ack cycle, then the IDLE grant cycle).
- Throughput: at most one outstanding request. No grant is issued while mem_req is high.
- mem_ack in IDLE is ignored: no state change, no push.
- opd_fifo_full rising during RD_WAIT is legal; space was reserved at grant.
- Async reset mid-transaction drops mem_req immediately. The popped command is lost; software re-issues.
- streak saturates at WR_STREAK_MAX and never wraps.

Decomposition:
- Shared package vmx_pkg holds:
  - state encoding localparams: IDLE=2'b00, WR_WAIT=2'b01, RD_WAIT=2'b10
  - ADDR_W/DATA_W defaults, shared with vmx_control_processor
- Optional sub-module vmx_rw_grant: a purely combinational grant decision on wr_ok, rd_ok and streak. All state lives in the top.

Test Plan:
- Single read: rd addr 0x1000_0004, mem_ack 3 cycles after mem_req with rdata 0xDEADBEEF -> one rd_fifo_rena, mem_addr=0x1000_0004 with mem_we=0, one opd_fifo_wren with data 0xDEADBEEF one cycle after ack.
- Simultaneous read and write eligible from empty state: wr addr 0x2000_0000, data 0x1234_5678 -> write issued first (mem_we=1, wdata 0x12345678), read issued after its ack.
- Starvation limit: 8 writes queued, 1 read queued, WR_STREAK_MAX=4, ack every request next cycle -> order W,W,W,W,R,W,W,W,W.
- Back-pressure: opd_fifo_full=1 with reads queued -> no rd_fifo_rena and no mem_req. Release full -> read granted that cycle.
- Missing result data: wr queue non-empty, res_fifo_empty=1 -> no write grant. A queued read proceeds instead.
- Reset mid-RD_WAIT: deassert rst_n before ack -> mem_req=0 and busy=0 immediately. Spurious mem_ack after reset release -> no opd_fifo_wren. Misaligned address 0x...07 -> mem_addr ends in 0x4.
